// File: rtl/mux_select_sequencer.sv
// Rotation-offset sequencer producing per-display 3-bit character-mux selects.
// Optional ping-pong rotation is compiled in with `define BOUNCE_EN.
module mux_select_sequencer #(
   parameter int CLK_DIV      = 50000000,
   parameter int NUM_CHARS    = 8,
   parameter int NUM_DISPLAYS = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      dir,
   input  logic                      step,
   input  logic                      load,
   input  logic [2:0]                loadval,
   output logic [3*NUM_DISPLAYS-1:0] sel,
   output logic [2:0]                offset,
   output logic                      tick,
   output logic                      wrap,
   output logic                      running
);

   localparam int                CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [2:0]       LAST     = 3'(NUM_CHARS - 1);
   localparam logic [3:0]       N4       = 4'(NUM_CHARS);

   typedef enum logic {PAUSED, RUNNING} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count;
   logic             step_q;
   logic             step_evt;
   logic             advance;
   logic             dir_eff;
   logic             at_boundary;
   logic [2:0]       offset_adv;
   logic [2:0]       load_offset;

   // NOTE: clocked state uses <= so every flop samples pre-edge values,
   // independent of the order the always_ff blocks are evaluated in.
   always_ff @(posedge clock) begin
      if (reset) state <= PAUSED;
      else       state <= state_next;
   end

   // NOTE: each always_comb assigns its outputs a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         PAUSED:  if (run)  state_next = RUNNING;
         RUNNING: if (!run) state_next = PAUSED;
         default: state_next = PAUSED;
      endcase
   end

   always_comb begin
      running = (state == RUNNING);
      tick    = running && (count == CNT_LAST);
   end

   // Prescaler freezes while paused so a resumed run continues the same period.
   always_ff @(posedge clock) begin
      if (reset)                  count <= '0;
      else if (state == RUNNING)  count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) step_q <= 1'b0;
      else       step_q <= step;
   end

   assign step_evt    = step & ~step_q;
   assign advance     = tick | (step_evt & (state == PAUSED));
   assign load_offset = ({1'b0, loadval} >= N4) ? 3'd0 : loadval;

`ifdef BOUNCE_EN
   logic dir_int;

   assign dir_eff = dir ^ dir_int;

   always_ff @(posedge clock) begin
      if (reset || load)               dir_int <= 1'b0;
      else if (advance && at_boundary) dir_int <= ~dir_int;
   end
`else
   assign dir_eff = dir;
`endif

   always_comb begin
      at_boundary = dir_eff ? (offset == 3'd0) : (offset == LAST);
      offset_adv  = dir_eff ? offset - 3'd1 : offset + 3'd1;
      if (at_boundary) begin
`ifdef BOUNCE_EN
         // Reflect off the boundary instead of crossing it.
         offset_adv = dir_eff ? 3'd1 : LAST - 3'd1;
`else
         offset_adv = dir_eff ? LAST : 3'd0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         offset <= 3'd0;
         wrap   <= 1'b0;
      end else if (load) begin
         offset <= load_offset;
         wrap   <= 1'b0;
      end else if (advance) begin
         offset <= offset_adv;
         wrap   <= at_boundary;
      end else begin
         wrap   <= 1'b0;
      end
   end

   // 4-bit sum keeps (offset + k) from overflowing when NUM_CHARS is 8.
   for (genvar k = 0; k < NUM_DISPLAYS; k++) begin : g_sel
      localparam logic [3:0] K_MOD = 4'(k % NUM_CHARS);
      logic [3:0] sum;
      logic [3:0] red;
      assign sum           = {1'b0, offset} + K_MOD;
      assign red           = (sum >= N4) ? sum - N4 : sum;
      assign sel[3*k +: 3] = red[2:0];
   end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Scoreboard bench for mux_select_sequencer: expected offset/wrap events are
// queued by the stimulus and popped by a monitor whenever the offset moves or wraps.
module tb_mux_select_sequencer;

`ifdef BOUNCE_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 4;
`endif

   typedef struct packed {
      logic [2:0] off;
      logic       wr;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, run, dir, step, load;
   logic [2:0]  loadval;
   logic [14:0] sel;
   logic [2:0]  offset;
   logic        tick, wrap, running;

   logic        load6;
   logic [2:0]  loadval6;
   logic [14:0] sel6;
   logic [2:0]  offset6;
   logic        tick6, wrap6, running6;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   logic [2:0]  prev_off;

   always #5 clock = ~clock;

   mux_select_sequencer #(.CLK_DIV(DIV), .NUM_CHARS(8), .NUM_DISPLAYS(5)) dut (
      .clock(clock), .reset(reset), .run(run), .dir(dir), .step(step),
      .load(load), .loadval(loadval), .sel(sel), .offset(offset),
      .tick(tick), .wrap(wrap), .running(running)
   );

   mux_select_sequencer #(.CLK_DIV(4), .NUM_CHARS(6), .NUM_DISPLAYS(5)) dut6 (
      .clock(clock), .reset(reset), .run(1'b0), .dir(1'b0), .step(1'b0),
      .load(load6), .loadval(loadval6), .sel(sel6), .offset(offset6),
      .tick(tick6), .wrap(wrap6), .running(running6)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int off, input bit wr);
      exp_t e;
      e.off = 3'(off);
      e.wr  = wr;
      sb.push_back(e);
   endtask

   task automatic negs(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [14:0] sel_of(input int off, input int n);
      logic [14:0] r;
      r = '0;
      for (int k = 0; k < 5; k++) r[3*k +: 3] = 3'((off + k) % n);
      return r;
   endfunction

   // Monitor: any offset change or wrap pulse is an output event to score.
   always @(negedge clock) begin
      exp_t e;
      if (mon_en && (offset !== prev_off || wrap !== 1'b0)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: offset %0d wrap %0b with nothing expected (t=%0t)",
                     offset, wrap, $time);
         end else begin
            e = sb.pop_front();
            check("sb_offset", 32'(offset), 32'(e.off));
            check("sb_wrap",   32'(wrap),   32'(e.wr));
            check("sb_sel",    32'(sel),    32'(sel_of(int'(e.off), 8)));
         end
      end
      prev_off = offset;
   end

   initial begin
      logic [7:0] pat;
      reset = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0; loadval = 3'd0;
      load6 = 1'b0; loadval6 = 3'd0;
      pat = '0;
      negs(3);

      check("rst_offset",  32'(offset),  32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_wrap",    32'(wrap),    32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_sel",     32'(sel),     32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
      check("rst_sel6",    32'(sel6),    32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));

      mon_en = 1'b1;
      reset  = 1'b0;
      run    = 1'b1;

`ifndef BOUNCE_EN
      // Forward rotation: 1..7 then wrap to 0.
      for (int i = 1; i <= 7; i++) push(i, 1'b0);
      push(0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         negs(1);
         pat[i] = tick;
         if (i == 4) check("sel_first_tick", 32'(sel), 32'({3'd5, 3'd4, 3'd3, 3'd2, 3'd1}));
      end
      check("tick_every_4", 32'(pat), 32'(8'b1000_1000));
      negs(25);

      // Reverse from 0 wraps to 7; a held step while running adds nothing.
      dir  = 1'b1;
      step = 1'b1;
      push(7, 1'b1);
      negs(4);
      check("sel_dir1_d1d0", 32'(sel[5:0]), 32'({3'd0, 3'd7}));
      run  = 1'b0;
      step = 1'b0;
      negs(1);
      check("paused_running", 32'(running), 32'd0);

      // Step held for 10 cycles while paused: exactly one decrement.
      step = 1'b1;
      push(6, 1'b0);
      negs(10);
      check("step_held_offset", 32'(offset), 32'd6);
      step = 1'b0;
      dir  = 1'b0;
      run  = 1'b1;

      // Prescaler resumes from held count 1: tick two cycles after running.
      negs(3);
      check("tick_resume", 32'(tick), 32'd1);
      load    = 1'b1;
      loadval = 3'd5;
      push(5, 1'b0);
      negs(1);
      load = 1'b0;

      // Pause with the prescaler held at 2, resume 20 cycles later.
      negs(1);
      run = 1'b0;
      negs(1);
      check("pause2_running", 32'(running), 32'd0);
      negs(20);
      run = 1'b1;
      negs(1);
      check("resume_running", 32'(running), 32'd1);
      check("resume_no_tick", 32'(tick),    32'd0);
      push(6, 1'b0);
      negs(1);
      check("resume_tick", 32'(tick), 32'd1);
      negs(1);

      // Reset mid-run.
      reset = 1'b1;
      push(0, 1'b0);
      negs(1);
      check("midrst_offset",  32'(offset),  32'd0);
      check("midrst_tick",    32'(tick),    32'd0);
      check("midrst_wrap",    32'(wrap),    32'd0);
      check("midrst_running", 32'(running), 32'd0);
      check("midrst_sel",     32'(sel),     32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
      reset = 1'b0;
      run   = 1'b0;
`else
      // Ping-pong: 1..7, reflect to 6 (wrap), down to 0, reflect to 1 (wrap).
      for (int i = 1; i <= 7; i++) push(i, 1'b0);
      push(6, 1'b1);
      for (int i = 5; i >= 0; i--) push(i, 1'b0);
      push(1, 1'b1);
      negs(31);
      run = 1'b0;
      check("bounce_offset", 32'(offset), 32'd1);
`endif

      // Load reduction on a 6-slot instance.
      negs(1);
      load6    = 1'b1;
      loadval6 = 3'd4;
      negs(1);
      check("n6_load4",     32'(offset6), 32'd4);
      check("n6_sel_off4",  32'(sel6),    32'({3'd2, 3'd1, 3'd0, 3'd5, 3'd4}));
      loadval6 = 3'd7;
      negs(1);
      check("n6_load7",     32'(offset6), 32'd0);
      loadval6 = 3'd5;
      negs(1);
      check("n6_load5",     32'(offset6), 32'd5);
      check("n6_sel_off5",  32'(sel6),    32'({3'd3, 3'd2, 3'd1, 3'd0, 3'd5}));
      loadval6 = 3'd6;
      negs(1);
      check("n6_load6",     32'(offset6), 32'd0);
      load6 = 1'b0;

      negs(5);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
Generates the 3-bit select codes that drive the 3-bit 8-to-1 character multiplexers behind the HEX displays, producing the rotating-word effect. It holds a rotation offset that advances on a prescaled tick or on a manual step. Each display k receives select (offset + k) mod NUM_CHARS. It sits between the board switches/keys and the per-display character muxes.

Parameters:
CLK_DIV, 50000000, clock cycles per rotation tick (1 Hz at 50 MHz); legal range >= 2
NUM_CHARS, 8, rotation period in character slots (word letters plus blank slots); legal range 2..8
NUM_DISPLAYS, 5, number of select outputs generated

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  level; 1 = auto-rotate on tick, 0 = paused
Dir  input  1  0 = offset increments (word moves left), 1 = offset decrements
Step  input  1  manual advance request, rising-edge detected internally
Load  input  1  one-cycle strobe: offset <= LoadVal
LoadVal  input  3  offset to load; values >= NUM_CHARS are reduced to 0
Sel  output  3*NUM_DISPLAYS  concatenated selects; Sel[3k+2:3k] drives display k
Offset  output  3  current rotation offset register
Tick  output  1  one-cycle pulse when the prescaler expires
Wrap  output  1  one-cycle pulse when the offset wraps (N-1->0 or 0->N-1)
Running  output  1  1 while the FSM is in RUNNING

Behaviour:
- Reset (synchronous, wins over everything): offset=0, prescaler=0, FSM=PAUSED, step-edge register=0. Tick=0, Wrap=0, Running=0. Sel display k = k mod NUM_CHARS.
- FSM states: PAUSED and RUNNING.
  - PAUSED->RUNNING on the cycle Run=1.
  - RUNNING->PAUSED on the cycle Run=0.
  - Running is a registered output equal to (state==RUNNING).
- Prescaler:
  - Counts 0..CLK_DIV-1 only while in RUNNING. Tick=1 in the cycle the count equals CLK_DIV-1; the count returns to 0 on the next edge.
  - On entering PAUSED the prescaler holds its value. It resumes from that value when running again; it is not restarted.
- Step edge: step_q registers Step each cycle. A step event is (Step & ~step_q). Step events are honoured only in PAUSED and ignored in RUNNING.
- Advance condition: Tick (RUNNING) or step event (PAUSED).
  - On advance, offset moves by +1 mod NUM_CHARS (Dir=0) or -1 mod NUM_CHARS (Dir=1). The new offset is visible the cycle after the advance condition.
- Load:
  - Highest priority after Reset. If Load and an advance coincide, Load wins and the advance is lost.
  - Load does not touch the prescaler or the FSM. Wrap=0 on a load.
- Wrap:
  - Registered. Asserts in the same cycle the new offset appears, when the advance crossed the N-1/0 boundary in either direction.
- Sel: combinational from the offset register. Display k = (offset + k) mod NUM_CHARS, computed with a 4-bit intermediate so there is no overflow when NUM_CHARS=8.
- Dir changes take effect at the next advance. There is no glitch on the offset.
- Run toggling mid-count: there is no partial advance. Only a full prescaler expiry advances the offset.

Optional Feature:
Macro: BOUNCE_EN
- Defined: ping-pong mode.
  - An internal direction bit is XORed with Dir. It toggles whenever an advance would wrap; that advance instead moves one step back from the boundary.
  - Example, NUM_CHARS=8, Dir=0: offsets run 6,7,6,5…0,1.
  - Wrap pulses on each reversal. Reset clears the internal bit. Load clears the internal bit.
- Undefined: plain circular wrap as above; there is no internal direction bit.

Test Plan:
1. Reset, CLK_DIV=4, Run=1, Dir=0 -> Tick every 4th cycle; offset 0,1,2…7,0. Wrap pulses on the 7->0 transition. Sel after the first tick = {5,4,3,2,1} (display 4..0).
2. Run=1, Dir=1 from offset 0 -> offset 7 after the first tick with Wrap=1. Sel display0=7, display1=0.
3. Run=0, Step held high for 10 cycles -> exactly one advance. Step held high while Run=1 -> no extra advance beyond ticks.
4. Load=1, LoadVal=5 in the same cycle as Tick -> offset=5 next cycle, Wrap=0. LoadVal=7 with NUM_CHARS=6 -> offset=0.
5. Run dropped at prescaler count 2, raised 20 cycles later -> the next Tick occurs 1 cycle after Running returns high. Reset asserted mid-run -> all outputs at reset values next cycle.
6. BOUNCE_EN defined, Dir=0, CLK_DIV=2 -> offset sequence 0..7,6,5…0,1 with Wrap at 7->6 and 0->1.
